// File: rtl/life_gen_engine.sv
// Game-of-Life generation engine: scans the front board through a 1-cycle read port,
// counts toroidal neighbours per cell, writes the next state to the back board, then swaps.
module life_gen_engine #(
    parameter int unsigned MAP_WIDTH  = 8,
    parameter int unsigned MAP_HEIGHT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic        step,
    output logic [7:0]  rAddrR,
    output logic [7:0]  rAddrC,
    input  logic        rd_data,
    output logic [7:0]  wAddrR,
    output logic [7:0]  wAddrC,
    output logic        write_en,
    output logic        write_data,
    output logic        swap,
    output logic        busy,
    output logic [15:0] gen_count
);

    localparam logic [7:0] ROW_LAST = 8'(MAP_HEIGHT - 1);
    localparam logic [7:0] COL_LAST = 8'(MAP_WIDTH - 1);
    localparam logic [3:0] K_LAST   = 4'd8;
    localparam logic [3:0] K_CENTRE = 4'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EVAL,
        S_WRITE,
        S_SWAP
    } state_t;

    state_t      state, state_n;
    logic        step_d;
    logic [3:0]  k, k_n;
    logic [7:0]  row, row_n;
    logic [7:0]  col, col_n;
    logic [3:0]  cnt, cnt_n;
    logic        centre, centre_n;
    logic [7:0]  raddr_r_n, raddr_c_n;
    logic [7:0]  waddr_r_n, waddr_c_n;
    logic        write_en_n, write_data_n;
    logic        swap_n, busy_n;
    logic [15:0] gen_count_n;
    logic        trigger_c;
    logic [3:0]  cnt_fin_c;
    logic        last_cell_c;

    // Neighbour row for scan index k: k 0-2 above, 3-5 same row, 6-8 below (wrapping).
    function automatic logic [7:0] nb_row(input logic [7:0] r, input logic [3:0] kk);
        logic [7:0] res;
        res = r;
        if (kk <= 4'd2)
            res = (r == 8'd0) ? ROW_LAST : r - 8'd1;
        else if (kk >= 4'd6)
            res = (r == ROW_LAST) ? 8'd0 : r + 8'd1;
        return res;
    endfunction

    // Neighbour column for scan index k: k%3 == 0 left, 1 same, 2 right (wrapping).
    function automatic logic [7:0] nb_col(input logic [7:0] c, input logic [3:0] kk);
        logic [7:0] res;
        res = c;
        if (kk == 4'd0 || kk == 4'd3 || kk == 4'd6)
            res = (c == 8'd0) ? COL_LAST : c - 8'd1;
        else if (kk == 4'd2 || kk == 4'd5 || kk == 4'd8)
            res = (c == COL_LAST) ? 8'd0 : c + 8'd1;
        return res;
    endfunction

    assign trigger_c   = step & ~step_d & mode & (state == S_IDLE);
    assign cnt_fin_c   = cnt + 4'(rd_data);
    assign last_cell_c = (row == ROW_LAST) && (col == COL_LAST);

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_n      = state;
        k_n          = k;
        row_n        = row;
        col_n        = col;
        cnt_n        = cnt;
        centre_n     = centre;
        raddr_r_n    = rAddrR;
        raddr_c_n    = rAddrC;
        waddr_r_n    = wAddrR;
        waddr_c_n    = wAddrC;
        write_en_n   = 1'b0;
        write_data_n = write_data;
        swap_n       = 1'b0;
        busy_n       = busy;
        gen_count_n  = gen_count;

        case (state)
            S_IDLE: begin
                if (trigger_c) begin
                    state_n   = S_READ;
                    busy_n    = 1'b1;
                    row_n     = 8'd0;
                    col_n     = 8'd0;
                    k_n       = 4'd0;
                    cnt_n     = 4'd0;
                    raddr_r_n = nb_row(8'd0, 4'd0);
                    raddr_c_n = nb_col(8'd0, 4'd0);
                end
            end
            S_READ: begin
                // Data arriving now belongs to scan index k-1.
                if (k != 4'd0) begin
                    if (k - 4'd1 == K_CENTRE)
                        centre_n = rd_data;
                    else
                        cnt_n = cnt_fin_c;
                end
                if (k == K_LAST) begin
                    state_n = S_EVAL;
                end else begin
                    k_n       = k + 4'd1;
                    raddr_r_n = nb_row(row, k + 4'd1);
                    raddr_c_n = nb_col(col, k + 4'd1);
                end
            end
            S_EVAL: begin
                state_n      = S_WRITE;
                write_en_n   = 1'b1;
                waddr_r_n    = row;
                waddr_c_n    = col;
                write_data_n = (cnt_fin_c == 4'd3) | (centre & (cnt_fin_c == 4'd2));
            end
            S_WRITE: begin
                if (last_cell_c) begin
                    state_n     = S_SWAP;
                    swap_n      = 1'b1;
                    gen_count_n = gen_count + 16'd1;
                end else begin
                    state_n = S_READ;
                    k_n     = 4'd0;
                    cnt_n   = 4'd0;
                    if (col == COL_LAST) begin
                        col_n = 8'd0;
                        row_n = row + 8'd1;
                    end else begin
                        col_n = col + 8'd1;
                    end
                    raddr_r_n = nb_row(row_n, 4'd0);
                    raddr_c_n = nb_col(col_n, 4'd0);
                end
            end
            S_SWAP: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
        endcase

        // Leaving run mode mid-generation abandons it without a swap.
        if (!mode && (state == S_READ || state == S_EVAL || state == S_WRITE)) begin
            state_n     = S_IDLE;
            busy_n      = 1'b0;
            write_en_n  = 1'b0;
            swap_n      = 1'b0;
            gen_count_n = gen_count;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            step_d     <= 1'b0;
            k          <= 4'd0;
            row        <= 8'd0;
            col        <= 8'd0;
            cnt        <= 4'd0;
            centre     <= 1'b0;
            rAddrR     <= 8'd0;
            rAddrC     <= 8'd0;
            wAddrR     <= 8'd0;
            wAddrC     <= 8'd0;
            write_en   <= 1'b0;
            write_data <= 1'b0;
            swap       <= 1'b0;
            busy       <= 1'b0;
            gen_count  <= 16'd0;
        end else begin
            state      <= state_n;
            step_d     <= step;
            k          <= k_n;
            row        <= row_n;
            col        <= col_n;
            cnt        <= cnt_n;
            centre     <= centre_n;
            rAddrR     <= raddr_r_n;
            rAddrC     <= raddr_c_n;
            wAddrR     <= waddr_r_n;
            wAddrC     <= waddr_c_n;
            write_en   <= write_en_n;
            write_data <= write_data_n;
            swap       <= swap_n;
            busy       <= busy_n;
            gen_count  <= gen_count_n;
        end
    end

endmodule

// File: tb/tb_life_gen_engine.sv
// Bench for life_gen_engine: board memory model, reference Life rule, write scoreboard.
module tb_life_gen_engine;

    localparam int W = 8;
    localparam int H = 8;
    localparam int GEN_CYCLES = 11 * W * H + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        step;
    logic [7:0]  rAddrR, rAddrC, wAddrR, wAddrC;
    logic        rd_data = 1'b0;
    logic        write_en, write_data, swap, busy;
    logic [15:0] gen_count;

    life_gen_engine #(.MAP_WIDTH(W), .MAP_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .mode(mode), .step(step),
        .rAddrR(rAddrR), .rAddrC(rAddrC), .rd_data(rd_data),
        .wAddrR(wAddrR), .wAddrC(wAddrC), .write_en(write_en),
        .write_data(write_data), .swap(swap), .busy(busy), .gen_count(gen_count)
    );

    always #5 clk = ~clk;

    logic front [H][W];
    logic back  [H][W];

    typedef struct {
        int   r;
        int   c;
        logic v;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  tests = 0;
    int  fails = 0;
    int  wr_seen = 0;
    int  exp_gen = 0;

    // Board memory: registered read of the front board, write port into the back board.
    always @(posedge clk) begin
        rd_data <= front[int'(rAddrR) % H][int'(rAddrC) % W];
        if (write_en)
            back[int'(wAddrR) % H][int'(wAddrC) % W] <= write_data;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the next expected cell update.
    always @(negedge clk) begin
        if (rst && write_en) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected write: row %0d col %0d data %0d, expected none",
                         wAddrR, wAddrC, write_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("write row", int'(wAddrR), mon_e.r);
                check("write col", int'(wAddrC), mon_e.c);
                check($sformatf("write data (%0d,%0d)", mon_e.r, mon_e.c),
                      int'(write_data), int'(mon_e.v));
            end
        end
    end

    // Reference model: toroidal neighbour sum with modular indexing, B3/S23 rule.
    task automatic push_expected();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int n;
                wr_t e;
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            n += int'(front[(r + dr + H) % H][(c + dc + W) % W]);
                e.r = r;
                e.c = c;
                e.v = (n == 3) || (front[r][c] && n == 2);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic clear_front();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                front[r][c] = 1'b0;
    endtask

    task automatic random_front(input int density_pct);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                front[r][c] = ($urandom_range(99) < density_pct);
    endtask

    function automatic int live_back();
        int n;
        n = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                n += int'(back[r][c]);
        return n;
    endfunction

    // One generation. abort_at > 0 drops mode at that cycle; restep_at > 0 re-pulses step.
    task automatic run_gen(input string name, input int abort_at, input int restep_at);
        int n, swaps, sw_at, busy_after;
        push_expected();
        wr_seen    = 0;
        swaps      = 0;
        sw_at      = -1;
        busy_after = -1;
        @(negedge clk) step = 1'b1;
        @(posedge clk);
        n = 0;
        while (n < 1600) begin
            @(negedge clk);
            n++;
            if (swap) begin
                swaps++;
                if (sw_at < 0) sw_at = n;
            end
            if (sw_at > 0 && n == sw_at + 1) busy_after = int'(busy);
            if (restep_at > 0 && n == restep_at - 50) step = 1'b0;
            if (restep_at > 0 && n == restep_at) step = 1'b1;
            if (abort_at > 0 && n == abort_at) begin
                mode = 1'b0;
                step = 1'b0;
            end
            if (abort_at > 0 && n == abort_at + 2)
                check({name, " busy after abort"}, int'(busy), 0);
        end
        step = 1'b0;
        if (abort_at > 0) begin
            check({name, " swaps"}, swaps, 0);
            check({name, " gen_count"}, int'(gen_count), exp_gen);
            exp_q.delete();
            mode = 1'b1;
        end else begin
            exp_gen = (exp_gen + 1) % 65536;
            check({name, " swaps"}, swaps, 1);
            check({name, " swap cycle"}, sw_at, GEN_CYCLES);
            check({name, " gen_count"}, int'(gen_count), exp_gen);
            check({name, " busy after swap"}, busy_after, 0);
            check({name, " write count"}, wr_seen, W * H);
            check({name, " leftover expected"}, exp_q.size(), 0);
            exp_q.delete();
            front = back;
        end
    endtask

    initial begin
        rst  = 1'b0;
        mode = 1'b1;
        step = 1'b0;
        clear_front();
        repeat (3) @(negedge clk);
        check("reset write_en", int'(write_en), 0);
        check("reset swap", int'(swap), 0);
        check("reset busy", int'(busy), 0);
        check("reset gen_count", int'(gen_count), 0);
        check("reset rAddrR", int'(rAddrR), 0);
        check("reset rAddrC", int'(rAddrC), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Blinker
        clear_front();
        front[3][2] = 1'b1; front[3][3] = 1'b1; front[3][4] = 1'b1;
        run_gen("blinker", 0, 0);
        check("blinker live", live_back(), 3);
        check("blinker (2,3)", int'(back[2][3]), 1);
        check("blinker (3,3)", int'(back[3][3]), 1);
        check("blinker (4,3)", int'(back[4][3]), 1);

        // Block split across all four corners
        clear_front();
        front[0][0] = 1'b1; front[0][7] = 1'b1; front[7][0] = 1'b1; front[7][7] = 1'b1;
        run_gen("torus block", 0, 0);
        check("torus live", live_back(), 4);
        check("torus (0,0)", int'(back[0][0]), 1);
        check("torus (7,7)", int'(back[7][7]), 1);

        clear_front();
        run_gen("empty", 0, 0);
        check("empty live", live_back(), 0);

        random_front(40);
        run_gen("restep ignored", 0, 100);

        random_front(35);
        run_gen("abort", 300, 0);

        // Reset mid-generation, then a clean generation from scratch
        random_front(45);
        push_expected();
        @(negedge clk) step = 1'b1;
        repeat (50) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset write_en", int'(write_en), 0);
        check("midreset swap", int'(swap), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset gen_count", int'(gen_count), 0);
        exp_gen = 0;
        exp_q.delete();
        step = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        run_gen("after reset", 0, 0);

        for (int i = 0; i < 4; i++) begin
            if (i == 0) random_front(30 + int'($urandom_range(30)));
            run_gen($sformatf("random gen %0d", i), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
